// File: rtl/lsu_pkg.sv
// Shared FUNCT3 codes, FSM states and access legality check for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RESP
  } lsu_state_t;

  // High for an unsupported width code or an address not aligned to the access size.
  function automatic logic access_err(input logic       write,
                                      input logic [2:0] funct3,
                                      input logic [1:0] off);
    logic invalid;
    logic misaligned;
    if (write) invalid = (funct3 >= 3'd3);
    else       invalid = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    misaligned = ((funct3[1:0] == 2'd1) && off[0]) ||
                 ((funct3[1:0] == 2'd2) && (off != 2'd0));
    return invalid || misaligned;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane select/extend for loads and read-modify-write merge for stores.
// Zero latency; no flow control.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{off, 3'b000} +: 8];
    lane_h = off[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_BU:   load_data = {24'h0, lane_b};
      F3_HU:   load_data = {16'h0, lane_h};
      default: load_data = word;
    endcase

    // Little-endian: lane 0 is bits [7:0].
    store_data = wdata;
    case (funct3)
      F3_B: begin
        store_data = word;
        store_data[{off, 3'b000} +: 8] = wdata[7:0];
      end
      F3_H:    store_data = off[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store sequencer onto a word-wide memory; DONE 1 (error), 2 (load/SW) or 3 (SB/SH) cycles after accept.
// REQ is only sampled in IDLE, so a held request is re-accepted after each RESP.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  input  logic              WRITE,
  input  logic [2:0]        FUNCT3,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [31:0]       WDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [31:0]       RDATA,
  output logic [ADDR_W-1:0] A,
  output logic [31:0]       WD,
  output logic              WE,
  input  logic [31:0]       RD
);

  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic              write_q;
  logic              err_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;
  logic [31:0]       load_data;
  logic [31:0]       store_data;

  lsu_byte_lane u_lane (
    .word       (word_q),
    .wdata      (wdata_q),
    .funct3     (funct3_q),
    .off        (addr_q[1:0]),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      word_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && REQ) begin
        addr_q   <= ADDR;
        funct3_q <= FUNCT3;
        write_q  <= WRITE;
        wdata_q  <= WDATA;
        err_q    <= access_err(WRITE, FUNCT3, ADDR[1:0]);
      end
      if (state_q == S_RD) word_q <= RD;
    end
  end

  always_comb begin
    state_d = state_q;
    BUSY    = (state_q != S_IDLE);
    DONE    = 1'b0;
    ERR     = 1'b0;
    RDATA   = '0;
    A       = '0;
    WD      = '0;
    WE      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (REQ) begin
          if (access_err(WRITE, FUNCT3, ADDR[1:0])) state_d = S_RESP;
          else if (WRITE && FUNCT3 == F3_W)         state_d = S_WR;
          else                                      state_d = S_RD;
        end
      end
      S_RD: begin
        A       = {addr_q[ADDR_W-1:2], 2'b00};
        state_d = write_q ? S_WR : S_RESP;
      end
      S_WR: begin
        A       = {addr_q[ADDR_W-1:2], 2'b00};
        WD      = store_data;
        WE      = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        DONE    = 1'b1;
        ERR     = err_q;
        RDATA   = (write_q || err_q) ? 32'h0 : load_data;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus random accesses against a word-array memory and an arithmetic reference model.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        REQ = 1'b0;
  logic        WRITE = 1'b0;
  logic [2:0]  FUNCT3 = 3'd0;
  logic [31:0] ADDR = 32'h0;
  logic [31:0] WDATA = 32'h0;
  logic        BUSY, DONE, ERR, WE;
  logic [31:0] RDATA, A, WD, RD;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic        mem_init = 1'b1;
  logic [31:0] last_rd;
  int          checks = 0;
  int          errors = 0;

  load_store_unit #(.ADDR_W(32)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WRITE(WRITE), .FUNCT3(FUNCT3),
    .ADDR(ADDR), .WDATA(WDATA), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .RDATA(RDATA), .A(A), .WD(WD), .WE(WE), .RD(RD)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'h8899AABB : ((32'(i) * 32'h9E3779B9) ^ 32'h5A5A0F0F);
  endfunction

  // Memory is never reset; it only accepts the write strobe.
  assign RD = mem[A[7:2]];
  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (WE) begin
      mem[A[7:2]] <= WD;
    end
  end

  function automatic logic [31:0] load_model(input logic [31:0] word, input logic [2:0] f3, input int off);
    logic [31:0] b, h;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (8 * (off & 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_model(input logic [31:0] word, input logic [31:0] wd, input logic [2:0] f3, input int off);
    case (f3)
      3'd0:    return (word & ~(32'hFF << (8 * off))) | ((wd & 32'hFF) << (8 * off));
      3'd1:    return (word & ~(32'hFFFF << (8 * (off & 2)))) | ((wd & 32'hFFFF) << (8 * (off & 2)));
      default: return wd;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] wd_in, input string tag);
    int          off, sz, lat, exp_lat, we_cnt, exp_we;
    logic        bad, got_err;
    logic [31:0] word, exp_rd, exp_wd, got_wd, got_a, got_rd;
    off    = int'(ad[1:0]);
    sz     = 1 << f3[1:0];
    word   = ref_mem[ad[7:2]];
    bad    = w ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    bad    = bad || ((off % sz) != 0);
    exp_rd = 32'h0; exp_wd = 32'h0; exp_we = 0;
    if (bad) exp_lat = 1;
    else if (!w) begin
      exp_lat = 2;
      exp_rd  = load_model(word, f3, off);
    end else begin
      exp_lat = (f3 == 3'd2) ? 2 : 3;
      exp_we  = 1;
      exp_wd  = store_model(word, wd_in, f3, off);
    end
    @(negedge CLK);
    chk({tag, "_idle_busy"}, 32'(BUSY), 32'd0);
    REQ = 1'b1; WRITE = w; FUNCT3 = f3; ADDR = ad; WDATA = wd_in;
    lat = 99; we_cnt = 0; got_wd = 0; got_a = 0; got_rd = 32'hDEAD; got_err = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      if (c == 1) REQ = 1'b0;
      if (WE) begin we_cnt++; got_wd = WD; got_a = A; end
      if (DONE) begin lat = c; got_rd = RDATA; got_err = ERR; break; end
    end
    last_rd = got_rd;
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_err"}, 32'(got_err), 32'(bad));
    chk({tag, "_rdata"}, got_rd, exp_rd);
    chk({tag, "_we_cycles"}, 32'(we_cnt), 32'(exp_we));
    if (exp_we == 1) begin
      chk({tag, "_wd"}, got_wd, exp_wd);
      chk({tag, "_a"}, got_a, {ad[31:2], 2'b00});
      ref_mem[ad[7:2]] = exp_wd;
    end
  endtask

  initial begin
    logic [7:0]  done_mask, idle_mask;
    logic [31:0] rd_first, rd_second, wval;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    repeat (3) @(negedge CLK);
    chk("reset_outputs", {29'h0, BUSY, DONE, ERR} | RDATA | A | WD | 32'(WE), 32'h0);
    mem_init = 1'b0;
    RST = 1'b1;

    access(1'b0, 3'd0, 32'h11, 32'h0, "lb_11");
    chk("lb_11_value", last_rd, 32'hFFFFFFAA);
    access(1'b0, 3'd4, 32'h13, 32'h0, "lbu_13");
    chk("lbu_13_value", last_rd, 32'h00000088);
    access(1'b0, 3'd1, 32'h12, 32'h0, "lh_12");
    chk("lh_12_value", last_rd, 32'hFFFF8899);
    access(1'b1, 3'd0, 32'h12, 32'h12345677, "sb_12");
    access(1'b0, 3'd2, 32'h10, 32'h0, "lw_10");
    chk("lw_10_value", last_rd, 32'h8877AABB);
    access(1'b1, 3'd2, 32'h15, 32'hCAFEF00D, "sw_15_misaligned");
    access(1'b0, 3'd1, 32'h13, 32'h0, "lh_13_misaligned");
    access(1'b0, 3'd3, 32'h10, 32'h0, "load_f3_3");
    access(1'b1, 3'd3, 32'h10, 32'h0, "store_f3_3");
    access(1'b1, 3'd1, 32'h22, 32'hABCD1234, "sh_22");
    access(1'b0, 3'd5, 32'h22, 32'h0, "lhu_22");

    // Reset while in RD: no write, no DONE, everything zero next cycle.
    @(negedge CLK);
    REQ = 1'b1; WRITE = 1'b1; FUNCT3 = 3'd1; ADDR = 32'h20; WDATA = 32'h5555;
    @(negedge CLK);
    REQ = 1'b0;
    chk("rst_rd_we", 32'(WE), 32'd0);
    chk("rst_rd_busy", 32'(BUSY), 32'd1);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_rd_outputs", {29'h0, BUSY, DONE, ERR} | RDATA | A | WD | 32'(WE), 32'h0);
    RST = 1'b1;
    access(1'b0, 3'd2, 32'h20, 32'h0, "lw_20_after_rst");

    // Reset during WR: the write at that edge still lands in memory.
    wval = 32'h0BAD_F00D;
    @(negedge CLK);
    REQ = 1'b1; WRITE = 1'b1; FUNCT3 = 3'd2; ADDR = 32'h24; WDATA = wval;
    @(negedge CLK);
    REQ = 1'b0;
    chk("rst_wr_we", 32'(WE), 32'd1);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_wr_outputs", {29'h0, BUSY, DONE, ERR} | RDATA | A | WD | 32'(WE), 32'h0);
    RST = 1'b1;
    ref_mem[9] = wval;
    access(1'b0, 3'd2, 32'h24, 32'h0, "lw_24_after_wr_rst");

    // Held REQ: LW 0x00 then LW 0x04, one idle cycle between.
    @(negedge CLK);
    REQ = 1'b1; WRITE = 1'b0; FUNCT3 = 3'd2; ADDR = 32'h0;
    done_mask = 8'h0; idle_mask = 8'h0; rd_first = 32'h0; rd_second = 32'h0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      if (c == 1) ADDR = 32'h4;
      if (c == 4) REQ = 1'b0;
      if (DONE) begin
        done_mask[c] = 1'b1;
        if (c == 2) rd_first = RDATA;
        if (c == 5) rd_second = RDATA;
      end
      if (!BUSY) idle_mask[c] = 1'b1;
    end
    chk("held_req_done_cycles", 32'(done_mask), 32'h24);
    chk("held_req_idle_cycles", 32'(idle_mask), 32'h08);
    chk("held_req_rd0", rd_first, ref_mem[0]);
    chk("held_req_rd1", rd_second, ref_mem[1]);

    for (int n = 0; n < 80; n++) begin
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             32'($urandom_range(0, 255)), $urandom, "rand");
    end

    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of core and memory address.
REQ-002 SHALL have port CLK, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port RST, input, 1, synchronous active-low reset.
REQ-004 SHALL have port REQ, input, 1, core access request, sampled only in IDLE.
REQ-005 SHALL have port WRITE, input, 1, 1 = store, 0 = load.
REQ-006 SHALL have port FUNCT3, input, 3, RV32I width/sign code: LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2.
REQ-007 SHALL have port ADDR, input, ADDR_W, byte address from the core.
REQ-008 SHALL have port WDATA, input, 32, store data, right-aligned.
REQ-009 SHALL have port BUSY, output, 1, high in every non-IDLE state.
REQ-010 SHALL have port DONE, output, 1, single-cycle completion pulse.
REQ-011 SHALL have port ERR, output, 1, misaligned or invalid access, valid with DONE.
REQ-012 SHALL have port RDATA, output, 32, extended load result, valid with DONE.
REQ-013 SHALL have port A, output, ADDR_W, word address to Data_Memory, bits [1:0] always 0.
REQ-014 SHALL have port WD, output, 32, write data to Data_Memory.
REQ-015 SHALL have port WE, output, 1, Data_Memory write enable.
REQ-016 SHALL have port RD, input, 32, combinational read data from Data_Memory.

Function
REQ-017 SHALL implement states IDLE, RD, WR, RESP.
REQ-018 In IDLE with REQ=1 at an edge, SHALL capture ADDR, FUNCT3, WRITE and WDATA.
REQ-019 From IDLE, SHALL go to RD for a load, WR for SW, RD for SB/SH, and RESP with ERR=1 for misaligned or invalid access.
REQ-020 Misaligned SHALL mean halfword with ADDR[0]=1 or word with ADDR[1:0]!=0; invalid SHALL mean load FUNCT3 in {3,6,7} or store FUNCT3 >= 3.
REQ-021 In RD, SHALL drive A={ADDR[ADDR_W-1:2],2'b00}, WE=0, and capture RD at the edge; it SHALL then go to RESP for a load or WR for SB/SH.
REQ-022 In WR, SHALL drive A, WD and WE=1 for exactly one cycle, then go to RESP.
REQ-023 SW SHALL set WD=WDATA.
REQ-024 SB SHALL set WD to the captured word with byte lane ADDR[1:0] replaced by WDATA[7:0] (little-endian).
REQ-025 SH SHALL set WD to the captured word with halfword lane ADDR[1] replaced by WDATA[15:0].
REQ-026 Loads SHALL select lane ADDR[1:0] or ADDR[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
REQ-027 In RESP, SHALL drive DONE=1, RDATA (0 for stores and errors) and ERR, then go to IDLE.
REQ-028 Latency from accepting edge to DONE-high cycle SHALL be: error 1 cycle; load and SW 2 cycles; SB/SH 3 cycles.
REQ-029 WE SHALL never assert for an error access; A and WD SHALL hold 0 in IDLE.
REQ-030 REQ SHALL be ignored outside IDLE; a REQ held high SHALL be re-accepted in the IDLE cycle after RESP (minimum 1 idle cycle between accesses).

Reset
REQ-031 RST=0 at an edge SHALL force IDLE and clear all capture registers; BUSY, DONE, ERR, RDATA, A, WD and WE SHALL all be 0 on the following cycle.
REQ-032 Reset in RD SHALL produce no write and no DONE.
REQ-033 Reset asserted during WR SHALL let the memory write at that edge complete (memory is not reset); no DONE SHALL follow.

Structure
REQ-034 Package lsu_pkg SHALL hold the FUNCT3 constants and the state enumeration.
REQ-035 Lane extraction and merge SHALL live in one combinational sub-module, lsu_byte_lane; the FSM and registers SHALL stay in load_store_unit.

Verification
REQ-036 Memory word 0x10=0x8899AABB; LB 0x11 -> RDATA=0xFFFFFFAA, DONE 2 cycles after accept; LBU 0x13 -> 0x00000088; LH 0x12 -> 0xFFFF8899.
REQ-037 SB 0x12, WDATA=0x12345677, same word -> one WE cycle with WD=0x8877AABB; DONE 3 cycles after accept; word then reads 0x8877AABB.
REQ-038 SW 0x15 -> ERR=1 with DONE 1 cycle after accept, WE never high, RDATA=0; LH 0x13 and FUNCT3=3 load behave the same.
REQ-039 SH 0x20 with RST pulled low in RD -> no WE, next cycle all outputs 0, then a fresh LW 0x20 completes normally.
REQ-040 REQ held high for LW 0x00 then LW 0x04 -> two DONE pulses 3 cycles apart, BUSY low exactly one cycle between them.
